stack_arbiter: RTL and testbench

//  - Shares one 8x8-bit LIFO stack between NREQ requesters using round-robin arbitration.
//  - Each requester issues one push or pop per transaction; the block sequences the stack's push/pop strobes.
//  - Returns the popped data, or an error on overflow/underflow, with a one-cycle ack.
//  - Sits between client FSMs and the stack instance; it is the only driver of the stack's push/pop/din.

---
 rtl/stack_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/stack_arbiter.sv | 127 ++++++++++++
 tb/tb_stack_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared op codes and FSM state encodings for the stack arbiter.
// Imported by the arbiter top and its testbench.
package stack_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first set req bit at or above ptr, wrapping to bit 0.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            any_req
);

  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between NREQ requesters: IDLE grants, ISSUE strobes the stack,
// DONE returns a one-cycle ack with rdata/err. One transaction in flight, 3 cycles per op.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  op,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic             busy,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DW-1:0]    stk_din,
  input  logic [DW-1:0]    stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            op_q, op_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [IW-1:0]   arb_grant;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req),
    .ptr     (rr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      op_q    <= OP_PUSH;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ack      = '0;
    rdata    = '0;
    err      = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          op_d    = op[arb_grant];
          wdata_d = wdata[arb_grant*DW +: DW];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (op_q == OP_PUSH) begin
          if (!stk_full) begin
            stk_push = 1'b1;
            stk_din  = wdata_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          // stk_dout is the pre-pop top; it changes only after this edge
          if (!stk_empty) begin
            stk_pop = 1'b1;
            rdata_d = stk_dout;
          end else begin
            err_d = 1'b1;
          end
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ack[grant_q] = 1'b1;
        rdata        = rdata_q;
        err          = err_q;
        rr_d         = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench: stack_arbiter (NREQ=2) driving a behavioural 8x8 LIFO.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              busy;
  logic              stk_push;
  logic              stk_pop;
  logic [DW-1:0]     stk_din;
  logic [DW-1:0]     stk_dout;
  logic              stk_full;
  logic              stk_empty;

  int n_tests;
  int n_fail;

  stack_arbiter #(
    .NREQ (NREQ),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  // Behavioural 8-deep LIFO with a registered top-of-stack output
  logic [DW-1:0] mem [8];
  logic [3:0]    sp;

  always @(posedge clk) begin
    if (rst) begin
      sp       <= 4'd0;
      stk_dout <= '0;
    end else if (stk_push && sp != 4'd8) begin
      mem[sp[2:0]] <= stk_din;
      sp           <= sp + 4'd1;
      stk_dout     <= stk_din;
    end else if (stk_pop && sp != 4'd0) begin
      sp       <= sp - 4'd1;
      stk_dout <= (sp >= 4'd2) ? mem[3'(sp - 4'd2)] : '0;
    end
  end

  assign stk_full  = (sp == 4'd8);
  assign stk_empty = (sp == 4'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction: ISSUE check, DONE check, back-to-IDLE check
  task automatic do_op(input int who, input logic o, input logic [DW-1:0] d,
                       input logic exp_err, input logic [DW-1:0] exp_rd, input string tag);
    logic [NREQ-1:0] exp_ack;
    logic            exp_push;
    logic            exp_pop;
    exp_ack  = '0;
    exp_ack[who] = 1'b1;
    exp_push = (o == OP_PUSH) && !exp_err;
    exp_pop  = (o == OP_POP) && !exp_err;
    req      = '0;
    req[who] = 1'b1;
    op[who]  = o;
    wdata[who*DW +: DW] = d;
    step();
    check({tag, ".push"}, 32'(stk_push), 32'(exp_push));
    check({tag, ".pop"},  32'(stk_pop),  32'(exp_pop));
    if (exp_push) check({tag, ".din"}, 32'(stk_din), 32'(d));
    check({tag, ".ack_early"}, 32'(ack), 32'd0);
    step();
    check({tag, ".ack"},   32'(ack),   32'(exp_ack));
    check({tag, ".err"},   32'(err),   32'(exp_err));
    check({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    check({tag, ".strobe_done"}, 32'({stk_push, stk_pop}), 32'd0);
    req[who] = 1'b0;
    step();
    check({tag, ".idle"}, 32'({ack, busy}), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] exp_ack;
    logic [DW-1:0]   exp_din;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = '0;
    op      = '0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ack",    32'(ack),   32'd0);
    check("rst.busy",   32'(busy),  32'd0);
    check("rst.rdata",  32'(rdata), 32'd0);
    check("rst.err",    32'(err),   32'd0);
    check("rst.strobe", 32'({stk_push, stk_pop}), 32'd0);
    check("rst.din",    32'(stk_din), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d", i), 32'({ack, busy, stk_push, stk_pop}), 32'd0);
    end

    do_op(0, OP_PUSH, 8'hA5, 1'b0, 8'h00, "push_a5");
    do_op(1, OP_POP,  8'h00, 1'b0, 8'hA5, "pop_a5");
    check("empty_after_pop", 32'(stk_empty), 32'd1);

    do_op(0, OP_POP, 8'h00, 1'b1, 8'h00, "pop_empty");

    // One entry already resident, so 0x07 fills the 8-deep stack
    do_op(1, OP_PUSH, 8'h5A, 1'b0, 8'h00, "push_5a");
    for (int i = 1; i <= 7; i++)
      do_op(0, OP_PUSH, 8'(i), 1'b0, 8'h00, $sformatf("push_%0d", i));
    check("full_flag", 32'(stk_full), 32'd1);
    do_op(0, OP_PUSH, 8'h08, 1'b1, 8'h00, "push_full");
    for (int i = 7; i >= 1; i--)
      do_op(0, OP_POP, 8'h00, 1'b0, 8'(i), $sformatf("pop_%0d", i));
    do_op(1, OP_POP, 8'h00, 1'b0, 8'h5A, "pop_5a");
    check("empty_after_drain", 32'(stk_empty), 32'd1);

    // Both requesters held high; last grant was req1 so rotation starts at 0
    op    = {OP_PUSH, OP_PUSH};
    wdata = {8'h20, 8'h10};
    req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_din = (k % 2 == 0) ? 8'h10 : 8'h20;
      step();
      check($sformatf("rr%0d.push", k), 32'(stk_push), 32'd1);
      check($sformatf("rr%0d.din", k),  32'(stk_din),  32'(exp_din));
      step();
      check($sformatf("rr%0d.ack", k),  32'(ack),      32'(exp_ack));
      check($sformatf("rr%0d.err", k),  32'(err),      32'd0);
      step();
      check($sformatf("rr%0d.busy", k), 32'(busy),     32'd0);
    end
    req = '0;
    do_op(0, OP_POP, 8'h00, 1'b0, 8'h20, "rr_last_pop");

    // Reset while a push is in ISSUE
    req      = 2'b01;
    op[0]    = OP_PUSH;
    wdata[7:0] = 8'h33;
    step();
    check("abort.issue_push", 32'(stk_push), 32'd1);
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    check("abort.ack",   32'(ack),       32'd0);
    check("abort.busy",  32'(busy),      32'd0);
    check("abort.empty", 32'(stk_empty), 32'd1);
    step();
    check("abort.quiet", 32'({ack, busy, stk_push, stk_pop}), 32'd0);

    do_op(0, OP_PUSH, 8'h44, 1'b0, 8'h00, "post_rst_push");
    do_op(1, OP_POP,  8'h00, 1'b0, 8'h44, "post_rst_pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
